ws2812_dec: RTL and testbench

WS2812 single-wire data decoder: samples an incoming NeoPixel data line, measures high-pulse widths to recover bits, assembles 24-bit GRB pixels and emits them with a pixel index. It detects the ≥51 µs low reset gap as end of frame. It sits at the input side of the controller, mirroring the transmit path: decoded pixels feed the 64-entry pixel RAM, and frame completion signals feed frame-ready logic.

---
 rtl/ws2812_dec_pkg.sv | 34 +++
 rtl/ws2812_dec_if.sv | 22 ++
 rtl/ws2812_dec_din_sync.sv | 63 ++++++
 rtl/ws2812_dec.sv | 173 +++++++++++++++++
 tb/tb_ws2812_dec.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_dec_pkg.sv
// ws2812_dec_pkg: shared state encoding, thresholds and widths for the WS2812 decoder.
// Optional build macro WS2812_DEC_FILTER_EN (used by ws2812_dec_din_sync).
package ws2812_dec_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned BIT_W  = 5;

  localparam logic [CNT_W-1:0] CNT_BIT_TH   = 16'd120;
  localparam logic [CNT_W-1:0] CNT_HIGH_MAX = 16'd240;
  localparam logic [CNT_W-1:0] CNT_RST      = 16'd10200;
  localparam logic [LEN_W-1:0] MAX_PIXELS   = 7'd64;
  localparam logic [BIT_W-1:0] BITS_PER_PIX = 5'd24;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0]  data;
    logic [ADDR_W-1:0] addr;
  } pixel_t;

  // Saturating increment for the pulse-width counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_dec_if.sv
// ws2812_dec_if: decoded pixel / frame status bus from the decoder to the pixel RAM side.
interface ws2812_dec_if;
  import ws2812_dec_pkg::*;

  logic              pixel_valid_out;
  logic [PIX_W-1:0]  pixel_data_out;
  logic [ADDR_W-1:0] pixel_addr_out;
  logic              frame_done_out;
  logic [LEN_W-1:0]  frame_len_out;
  logic              err_out;

  modport master (
    output pixel_valid_out, pixel_data_out, pixel_addr_out,
           frame_done_out, frame_len_out, err_out
  );

  modport slave (
    input pixel_valid_out, pixel_data_out, pixel_addr_out,
          frame_done_out, frame_len_out, err_out
  );

endinterface

// File: rtl/ws2812_dec_din_sync.sv
// ws2812_dec_din_sync: 2-FF synchronizer, optional deglitch (WS2812_DEC_FILTER_EN),
// and rise/fall pulse generation for the WS2812 data line.
module ws2812_dec_din_sync (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic i_din,
  output logic o_level_c,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Synchronize the asynchronous line and keep one cycle of history.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

`ifdef WS2812_DEC_FILTER_EN
  logic r_dly2;
  logic r_filt;
  logic w_all_hi;
  logic w_all_lo;

  // Three consecutive equal synchronized samples are needed to move the filtered level.
  assign w_all_hi = r_sync & r_dly & r_dly2;
  assign w_all_lo = ~(r_sync | r_dly | r_dly2);

  // Filtered level register; edges fire in the cycle the level is about to flip.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_dly2 <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_dly2 <= r_dly;
      if (w_all_hi) begin
        r_filt <= 1'b1;
      end else if (w_all_lo) begin
        r_filt <= 1'b0;
      end
    end
  end

  assign o_level_c = r_filt;
  assign o_rise_c  = w_all_hi & ~r_filt;
  assign o_fall_c  = w_all_lo & r_filt;
`else
  assign o_level_c = r_sync;
  assign o_rise_c  = r_sync & ~r_dly;
  assign o_fall_c  = ~r_sync & r_dly;
`endif

endmodule

// File: rtl/ws2812_dec.sv
// ws2812_dec: WS2812 single-wire decoder; measures high pulses, assembles GRB pixels,
// detects the reset gap as end of frame. Optional deglitch via WS2812_DEC_FILTER_EN.
module ws2812_dec
  import ws2812_dec_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          din_in,
  ws2812_dec_if.master  pix_if
);

  logic w_level_c;
  logic w_rise_c;
  logic w_fall_c;

  ws2812_dec_din_sync u_din_sync (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .i_din     (din_in),
    .o_level_c (w_level_c),
    .o_rise_c  (w_rise_c),
    .o_fall_c  (w_fall_c)
  );

  state_t            r_state,       w_state;
  logic [CNT_W-1:0]  r_high_cnt,    w_high_cnt;
  logic [CNT_W-1:0]  r_low_cnt,     w_low_cnt;
  logic [BIT_W-1:0]  r_bit_cnt,     w_bit_cnt;
  logic [LEN_W-1:0]  r_pix_cnt,     w_pix_cnt;
  logic              r_ovf,         w_ovf;
  logic [PIX_W-1:0]  r_shreg,       w_shreg;
  pixel_t            r_pix,         w_pix;
  logic              r_pix_valid,   w_pix_valid;
  logic              r_frame_done,  w_frame_done;
  logic [LEN_W-1:0]  r_frame_len,   w_frame_len;
  logic              r_err,         w_err;
  logic [PIX_W-1:0]  w_shift;

  // State, counters and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= ST_SYNC;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_ovf        <= 1'b0;
      r_shreg      <= '0;
      r_pix        <= '0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_len  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_high_cnt   <= w_high_cnt;
      r_low_cnt    <= w_low_cnt;
      r_bit_cnt    <= w_bit_cnt;
      r_pix_cnt    <= w_pix_cnt;
      r_ovf        <= w_ovf;
      r_shreg      <= w_shreg;
      r_pix        <= w_pix;
      r_pix_valid  <= w_pix_valid;
      r_frame_done <= w_frame_done;
      r_frame_len  <= w_frame_len;
      r_err        <= w_err;
    end
  end

  // Shift register contents if the current high pulse ends this cycle.
  assign w_shift = {r_shreg[PIX_W-2:0], (r_high_cnt >= CNT_BIT_TH)};

  // Next-state and output decode. Counters hold the cycles already spent in the
  // current level, so "+1" is the ordinal of the present cycle.
  always_comb begin
    w_state      = r_state;
    w_high_cnt   = r_high_cnt;
    w_low_cnt    = r_low_cnt;
    w_bit_cnt    = r_bit_cnt;
    w_pix_cnt    = r_pix_cnt;
    w_ovf        = r_ovf;
    w_shreg      = r_shreg;
    w_pix        = r_pix;
    w_pix_valid  = 1'b0;
    w_frame_done = 1'b0;
    w_frame_len  = r_frame_len;
    w_err        = 1'b0;

    case (r_state)
      ST_SYNC: begin
        if (w_level_c) begin
          w_low_cnt = '0;
        end else if (sat_inc(r_low_cnt) >= CNT_RST) begin
          w_low_cnt = '0;
          w_state   = ST_IDLE;
        end else begin
          w_low_cnt = sat_inc(r_low_cnt);
        end
      end

      ST_IDLE: begin
        if (w_rise_c) begin
          w_high_cnt = CNT_W'(1);
          w_state    = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (r_high_cnt > CNT_HIGH_MAX) begin
          // Stuck-high line: drop the frame silently and resynchronize.
          w_err      = 1'b1;
          w_bit_cnt  = '0;
          w_pix_cnt  = '0;
          w_ovf      = 1'b0;
          w_high_cnt = '0;
          w_low_cnt  = '0;
          w_state    = ST_SYNC;
        end else if (w_fall_c) begin
          w_shreg   = w_shift;
          w_low_cnt = CNT_W'(1);
          w_state   = ST_LOW;
          if (r_bit_cnt == BITS_PER_PIX - BIT_W'(1)) begin
            w_bit_cnt = '0;
            if (r_pix_cnt < MAX_PIXELS) begin
              w_pix_valid = 1'b1;
              w_pix.data  = w_shift;
              w_pix.addr  = r_pix_cnt[ADDR_W-1:0];
              w_pix_cnt   = r_pix_cnt + LEN_W'(1);
            end else begin
              w_ovf = 1'b1;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + BIT_W'(1);
          end
        end else begin
          w_high_cnt = sat_inc(r_high_cnt);
        end
      end

      ST_LOW: begin
        if (w_rise_c) begin
          w_high_cnt = CNT_W'(1);
          w_state    = ST_HIGH;
        end else if (sat_inc(r_low_cnt) >= CNT_RST) begin
          // Reset gap: close the frame, flag a partial pixel or dropped pixels.
          w_frame_done = 1'b1;
          w_frame_len  = r_pix_cnt;
          w_err        = (r_bit_cnt != '0) || r_ovf;
          w_bit_cnt    = '0;
          w_pix_cnt    = '0;
          w_ovf        = 1'b0;
          w_low_cnt    = '0;
          w_high_cnt   = '0;
          w_state      = ST_IDLE;
        end else begin
          w_low_cnt = sat_inc(r_low_cnt);
        end
      end

      default: begin
        w_state = ST_SYNC;
      end
    endcase
  end

  assign pix_if.pixel_valid_out = r_pix_valid;
  assign pix_if.pixel_data_out  = r_pix.data;
  assign pix_if.pixel_addr_out  = r_pix.addr;
  assign pix_if.frame_done_out  = r_frame_done;
  assign pix_if.frame_len_out   = r_frame_len;
  assign pix_if.err_out         = r_err;

endmodule

// File: tb/tb_ws2812_dec.sv
// tb_ws2812_dec: directed bench for ws2812_dec (honours WS2812_DEC_FILTER_EN if defined).
module tb_ws2812_dec;
  import ws2812_dec_pkg::*;

`ifdef WS2812_DEC_FILTER_EN
  localparam int EXTRA     = 2;
  localparam int GLITCH_AT = 10;
`else
  localparam int EXTRA     = 0;
  localparam int GLITCH_AT = -1;
`endif

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic din_in   = 1'b0;

  ws2812_dec_if pix_if ();

  ws2812_dec dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .din_in   (din_in),
    .pix_if   (pix_if)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [23:0] pd_q[$];
  logic [5:0]  pa_q[$];
  int          pc_q[$];
  logic [6:0]  fl_q[$];
  logic        fe_q[$];
  int          fc_q[$];
  int          err_lone = 0;
  int          err_cyc  = 0;
  int          last_fall = 0;

  // Capture DUT pulses away from the active edge.
  always @(negedge clk_in) begin
    if (pix_if.pixel_valid_out) begin
      pd_q.push_back(pix_if.pixel_data_out);
      pa_q.push_back(pix_if.pixel_addr_out);
      pc_q.push_back(cyc);
    end
    if (pix_if.frame_done_out) begin
      fl_q.push_back(pix_if.frame_len_out);
      fe_q.push_back(pix_if.err_out);
      fc_q.push_back(cyc);
    end
    if (pix_if.err_out && !pix_if.frame_done_out) begin
      err_lone++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clear_q();
    pd_q.delete(); pa_q.delete(); pc_q.delete();
    fl_q.delete(); fe_q.delete(); fc_q.delete();
  endtask

  // Send the top nbits of w, MSB first; optional 1-cycle glitch in one bit's low time.
  task automatic send_word(input logic [23:0] w, input int nbits,
                           input int h0, input int h1, input int lo0, input int lo1,
                           input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      int   h;
      int   lo;
      b  = w[23-i];
      h  = b ? h1 : h0;
      lo = b ? lo1 : lo0;
      din_in = 1'b1;
      tick(h);
      last_fall = cyc;
      din_in = 1'b0;
      if (i == glitch_bit) begin
        tick(lo / 2);
        din_in = 1'b1;
        tick(1);
        din_in = 1'b0;
        tick(lo - lo / 2 - 1);
      end else begin
        tick(lo);
      end
    end
  endtask

  task automatic send_fast(input logic [23:0] w, input int nbits);
    send_word(w, nbits, 3, 120, 3, 3, -1);
  endtask

  // Wait until a frame end from the last falling edge must have been reported.
  task automatic wait_frame();
    tick(last_fall + int'(CNT_RST) + 2 + EXTRA + 4 - cyc);
  endtask

  initial begin
    int hi_start;
    int pix_fall;

    // Reset values
    din_in   = 1'b0;
    rst_n_in = 1'b0;
    tick(3);
    chk("rst_valid", 32'(pix_if.pixel_valid_out), 32'd0);
    chk("rst_data",  32'(pix_if.pixel_data_out),  32'd0);
    chk("rst_addr",  32'(pix_if.pixel_addr_out),  32'd0);
    chk("rst_done",  32'(pix_if.frame_done_out),  32'd0);
    chk("rst_len",   32'(pix_if.frame_len_out),   32'd0);
    chk("rst_err",   32'(pix_if.err_out),         32'd0);
    rst_n_in = 1'b1;

    // Pixel before the initial reset gap has elapsed is ignored
    tick(500);
    send_fast(24'h111111, 24);
    tick(10210);
    chk("sync_valids", 32'(pd_q.size()), 32'd0);
    chk("sync_frames", 32'(fc_q.size()), 32'd0);
    chk("sync_err",    32'(err_lone),    32'd0);

    // Stuck-high mid-pixel: lone error 241 high cycles after the rise, no frame end
    clear_q();
    send_fast(24'hA80000, 5);
    hi_start = cyc;
    din_in = 1'b1;
    tick(300);
    din_in = 1'b0;
    tick(10210);
    chk("hi_err_cnt", 32'(err_lone),            32'd1);
    chk("hi_err_lat", 32'(err_cyc - hi_start),  32'(244 + EXTRA));
    chk("hi_frames",  32'(fc_q.size()),         32'd0);
    chk("hi_valids",  32'(pd_q.size()),         32'd0);

    // Full-timing pixel 0xA5C30F after recovery
    clear_q();
    send_word(24'hA5C30F, 24, 80, 160, 170, 90, GLITCH_AT);
    pix_fall = last_fall;
    wait_frame();
    chk("p1_count", 32'(pd_q.size()), 32'd1);
    if (pd_q.size() > 0) begin
      chk("p1_data", 32'(pd_q[0]),            32'h00A5C30F);
      chk("p1_addr", 32'(pa_q[0]),            32'd0);
      chk("p1_lat",  32'(pc_q[0] - pix_fall), 32'(3 + EXTRA));
    end
    chk("p1_frames", 32'(fc_q.size()), 32'd1);
    if (fc_q.size() > 0) begin
      chk("p1_len",   32'(fl_q[0]),            32'd1);
      chk("p1_ferr",  32'(fe_q[0]),            32'd0);
      chk("p1_f_lat", 32'(fc_q[0] - pix_fall), 32'(10202 + EXTRA));
    end
    chk("p1_lone_err", 32'(err_lone), 32'd1);

    // 66-pixel frame: 64 accepted, overflow reported with frame end
    clear_q();
    for (int i = 0; i < 66; i++) send_fast(24'(i), 24);
    wait_frame();
    chk("ov_count", 32'(pd_q.size()), 32'd64);
    for (int i = 0; i < 64; i++) begin
      if (i < pd_q.size()) begin
        chk($sformatf("ov_data%0d", i), 32'(pd_q[i]), 32'(i));
        chk($sformatf("ov_addr%0d", i), 32'(pa_q[i]), 32'(i));
      end
    end
    chk("ov_frames", 32'(fc_q.size()), 32'd1);
    if (fc_q.size() > 0) begin
      chk("ov_len",  32'(fl_q[0]), 32'd64);
      chk("ov_ferr", 32'(fe_q[0]), 32'd1);
    end

    // 12-bit partial pixel then reset gap
    clear_q();
    send_fast(24'hABC000, 12);
    wait_frame();
    chk("part_valids", 32'(pd_q.size()), 32'd0);
    chk("part_frames", 32'(fc_q.size()), 32'd1);
    if (fc_q.size() > 0) begin
      chk("part_len",  32'(fl_q[0]), 32'd0);
      chk("part_ferr", 32'(fe_q[0]), 32'd1);
    end
    chk("part_lone_err", 32'(err_lone), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
